// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, nstate;
  logic [WIDTH:0]  prem;
  logic [DW-1:0]   sreg;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]   cnt;

  logic [WIDTH:0]  shifted, trial, nprem;
  logic [DW-1:0]   nsreg;
  logic            last;

  // One restoring step; prem < dvs always holds, so its top bit is free to shift out.
  always_comb begin
    shifted = {prem[WIDTH-1:0], sreg[DW-1]};
    trial   = shifted - {1'b0, dvs};
    nprem   = trial[WIDTH] ? shifted : trial;
    nsreg   = {sreg[DW-2:0], ~trial[WIDTH]};
    last    = (cnt == CW'(DW - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    ready  = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) nstate = (divisor == '0) ? DONE : RUN;
      end
      RUN:  if (last) nstate = DONE;
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prem        <= '0;
      sreg        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvs  <= divisor;
          prem <= '0;
          sreg <= dividend;
          cnt  <= '0;
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
          end
        end
        RUN: begin
          prem <= nprem;
          sreg <= nsreg;
          cnt  <= cnt + CW'(1);
          if (last) begin
            quotient    <= nsreg;
            remainder   <= nprem[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table, corner sequences, exhaustive sweep.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       ready, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Issue one operation, return cycles from the start edge to the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
  endtask

  int lat, ndone;
  logic ok;

  initial begin
    vecs[0] = '{8'd6,   4'd2,  8'd3,   4'd0, 1'b0};
    vecs[1] = '{8'd15,  4'd1,  8'd15,  4'd0, 1'b0};
    vecs[2] = '{8'd25,  4'd5,  8'd5,   4'd0, 1'b0};
    vecs[3] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0};
    vecs[4] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    vecs[5] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
    vecs[6] = '{8'd100, 4'd0,  8'd255, 4'd0, 1'b1};
    vecs[7] = '{8'd9,   4'd4,  8'd2,   4'd1, 1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;

    // First op: ready must fall in the cycle after the start edge.
    @(negedge clk);
    start = 1'b1; dividend = 8'd6; divisor = 4'd2;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("ready falls", ready, 0);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("first latency", lat, 9);
    @(negedge clk);
    check("first ready back", ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d latency", i), lat, (vecs[i].b == 0) ? 1 : 9);
      check($sformatf("v%0d quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d dbz", i), div_by_zero, vecs[i].dbz);
      @(negedge clk);
      check($sformatf("v%0d done width", i), done, 0);
      check($sformatf("v%0d ready after", i), ready, 1);
    end

    // Start during RUN is ignored; outputs from 9/4 hold until completion.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold q in run", quotient, 2);
    check("hold r in run", remainder, 1);
    start = 1'b1; dividend = 8'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0; dividend = 8'd1; divisor = 4'd1;
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignored latency", lat, 9);
    check("ignored quotient", quotient, 28);
    check("ignored remainder", remainder, 4);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("single done", ndone, 0);
    check("idle hold q", quotient, 28);
    check("idle hold r", remainder, 4);

    // Asynchronous reset mid-RUN.
    run_op(8'd0, 4'd0, lat);
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst ready", ready, 1);
    check("async rst q", quotient, 0);
    check("async rst r", remainder, 0);
    check("async rst dbz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after rst", ndone, 0);
    run_op(8'd25, 4'd5, lat);
    check("post rst latency", lat, 9);
    check("post rst q", quotient, 5);
    check("post rst r", remainder, 0);

    // Exhaustive invariant sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), lat);
        if (b != 0)
          ok = (int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)
               && !div_by_zero && lat == 9;
        else
          ok = div_by_zero && quotient == 8'hff && remainder == 0 && lat == 1;
        check($sformatf("exh %0d/%0d q=%0d r=%0d lat=%0d", a, b, quotient, remainder, lat),
              ok, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
